// File: rtl/breath_led_seq.sv
// rtl/breath_led_seq.sv - program-table pattern sequencer driving the breath_led core
module breath_led_seq #(
  parameter int unsigned CLK_PER_MS    = 50000,
  parameter logic [9:0]  RST_FREQ_STEP = 10'd1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        prog_we,
  input  logic [1:0]  prog_addr,
  input  logic [27:0] prog_data,
  output logic        prog_err,
  output logic        set_en,
  output logic [9:0]  set_freq_step,
  output logic        sw_ctrl,
  output logic        busy,
  output logic [1:0]  cur_idx,
  output logic        done
);

  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_DWELL,
    S_NEXT
  } state_t;

  state_t         state_q, state_d;
  logic [27:0]    tbl_q [4];
  logic [1:0]     idx_q, idx_d;
  logic           set_en_q, set_en_d;
  logic [9:0]     step_q, step_d;
  logic           sw_q, sw_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [15:0]    dwell_q, dwell_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [27:0]    entry;
  logic           any_valid;
  logic           busy_w;

  assign entry     = tbl_q[idx_q];
  assign any_valid = tbl_q[0][27] | tbl_q[1][27] | tbl_q[2][27] | tbl_q[3][27];
  assign busy_w    = (state_q != S_IDLE);

  // Program table: writable only while idle, cleared by reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < 4; i++) tbl_q[i] <= '0;
    end else if (prog_we && !busy_w) begin
      tbl_q[prog_addr] <= prog_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      set_en_q <= 1'b0;
      step_q   <= RST_FREQ_STEP;
      sw_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dwell_q  <= 16'd0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      set_en_q <= set_en_d;
      step_q   <= step_d;
      sw_q     <= sw_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dwell_q  <= dwell_d;
      presc_q  <= presc_d;
    end
  end

  // Next-state logic; stop overrides every other event, including start.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    set_en_d = 1'b0;
    step_d   = step_q;
    sw_d     = sw_q;
    done_d   = 1'b0;
    err_d    = prog_we && busy_w;
    dwell_d  = dwell_q;
    presc_d  = presc_q;
    if (stop) begin
      state_d = S_IDLE;
      sw_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && any_valid) begin
            idx_d   = 2'd0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          state_d = entry[27] ? S_APPLY : S_NEXT;
        end
        S_APPLY: begin
          set_en_d = 1'b1;
          step_d   = entry[25:16];
          sw_d     = entry[26];
          dwell_d  = (entry[15:0] == 16'd0) ? 16'd1 : entry[15:0];
          presc_d  = '0;
          state_d  = S_DWELL;
        end
        S_DWELL: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            dwell_d = dwell_q - 16'd1;
            if (dwell_q == 16'd1) state_d = S_NEXT;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_NEXT: begin
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end else if (loop_en) begin
            idx_d   = 2'd0;
            state_d = S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign prog_err      = err_q;
  assign set_en        = set_en_q;
  assign set_freq_step = step_q;
  assign sw_ctrl       = sw_q;
  assign busy          = busy_w;
  assign cur_idx       = idx_q;
  assign done          = done_q;

endmodule

// File: tb/tb_breath_led_seq.sv
// tb/tb_breath_led_seq.sv - directed self-checking bench for breath_led_seq
module tb_breath_led_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        prog_we = 1'b0;
  logic [1:0]  prog_addr = 2'd0;
  logic [27:0] prog_data = 28'd0;
  logic        prog_err;
  logic        set_en;
  logic [9:0]  set_freq_step;
  logic        sw_ctrl;
  logic        busy;
  logic [1:0]  cur_idx;
  logic        done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ne = 0;
  int nd = 0;
  int ev_step [64];
  int ev_sw [64];
  int ev_cyc [64];
  int dn_cyc = 0;
  int dn_busy = 0;

  breath_led_seq #(.CLK_PER_MS(4), .RST_FREQ_STEP(10'd1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .loop_en(loop_en), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_err(prog_err), .set_en(set_en),
    .set_freq_step(set_freq_step), .sw_ctrl(sw_ctrl), .busy(busy),
    .cur_idx(cur_idx), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Log strobes away from the active edge.
  always @(negedge sys_clk) begin
    if (set_en && ne < 64) begin
      ev_step[ne] = int'(set_freq_step);
      ev_sw[ne]   = int'(sw_ctrl);
      ev_cyc[ne]  = cyc;
      ne = ne + 1;
    end
    if (done) begin
      dn_cyc  = cyc;
      dn_busy = int'(busy);
      nd = nd + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [27:0] mk(input logic v, input logic on, input logic [9:0] st, input logic [15:0] dw);
    return {v, on, st, dw};
  endfunction

  task automatic wr(input logic [1:0] a, input logic [27:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ev(input string tag, input int target);
    for (int i = 0; i < 300 && ne < target; i++) tick();
    check(tag, 32'(ne >= target), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 300 && nd < target; i++) tick();
    check(tag, 32'(nd >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_set_en"}, 32'(set_en), 32'd0);
    check({tag, "_step"}, 32'(set_freq_step), 32'd1);
    check({tag, "_sw"}, 32'(sw_ctrl), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_idx"}, 32'(cur_idx), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(prog_err), 32'd0);
  endtask

  initial begin
    int b;
    int d0;
    int st_cyc;

    // Reset, then start with an empty table.
    tick(); tick();
    sys_rst = 1'b0;
    check_reset_outputs("rst");
    pulse_start();
    repeat (6) tick();
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_setens", 32'(ne), 32'd0);
    check("empty_done", 32'(nd), 32'd0);

    // Single pass: e0={1,1,3,2} e1 invalid e2={1,0,10,1} e3={1,1,15,0}.
    wr(2'd0, mk(1'b1, 1'b1, 10'd3, 16'd2));
    wr(2'd1, mk(1'b0, 1'b1, 10'd9, 16'd5));
    wr(2'd2, mk(1'b1, 1'b0, 10'd10, 16'd1));
    wr(2'd3, mk(1'b1, 1'b1, 10'd15, 16'd0));
    tick();
    check("prog_err_idle", 32'(prog_err), 32'd0);
    b = ne; d0 = nd;
    loop_en = 1'b0;
    st_cyc = cyc;
    pulse_start();
    wait_done("single_done_seen", d0 + 1);
    check("single_count", 32'(ne - b), 32'd3);
    check("single_latency", 32'(ev_cyc[b] - st_cyc), 32'd3);
    check("single_step0", 32'(ev_step[b]), 32'd3);
    check("single_step1", 32'(ev_step[b+1]), 32'd10);
    check("single_step2", 32'(ev_step[b+2]), 32'd15);
    check("single_sw0", 32'(ev_sw[b]), 32'd1);
    check("single_sw1", 32'(ev_sw[b+1]), 32'd0);
    check("single_sw2", 32'(ev_sw[b+2]), 32'd1);
    check("single_gap02", 32'(ev_cyc[b+1] - ev_cyc[b]), 32'd13);
    check("single_gap23", 32'(ev_cyc[b+2] - ev_cyc[b+1]), 32'd7);
    // set_en cycle opens a 4-cycle DWELL, then NEXT, then done.
    check("single_done_gap", 32'(dn_cyc - ev_cyc[b+2]), 32'd5);
    check("single_done_busy", 32'(dn_busy), 32'd0);
    tick();
    check("single_done_once", 32'(nd - d0), 32'd1);
    check("single_sw_hold", 32'(sw_ctrl), 32'd1);
    check("single_idx", 32'(cur_idx), 32'd3);
    check("single_step_hold", 32'(set_freq_step), 32'd15);

    // Loop over e0 and e3, then clear loop_en mid-run.
    wr(2'd0, mk(1'b1, 1'b1, 10'd5, 16'd1));
    wr(2'd1, 28'd0);
    wr(2'd2, 28'd0);
    wr(2'd3, mk(1'b1, 1'b0, 10'd7, 16'd1));
    b = ne; d0 = nd;
    loop_en = 1'b1;
    pulse_start();
    wait_ev("loop_five", b + 5);
    check("loop_no_done", 32'(nd - d0), 32'd0);
    loop_en = 1'b0;
    wait_done("loop_done_seen", d0 + 1);
    check("loop_count", 32'(ne - b), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("loop_step%0d", i), 32'(ev_step[b+i]), (i % 2 == 0) ? 32'd5 : 32'd7);
    check("loop_gap03", 32'(ev_cyc[b+1] - ev_cyc[b]), 32'd11);
    check("loop_gap30", 32'(ev_cyc[b+2] - ev_cyc[b+1]), 32'd7);
    check("loop_done_gap", 32'(dn_cyc - ev_cyc[b+5]), 32'd5);

    // Stop mid-dwell.
    b = ne; d0 = nd;
    pulse_start();
    wait_ev("stop_first", b + 1);
    tick();
    check("stop_pre_sw", 32'(sw_ctrl), 32'd1);
    check("stop_pre_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_sw", 32'(sw_ctrl), 32'd0);
    check("stop_step", 32'(set_freq_step), 32'd5);
    repeat (10) tick();
    check("stop_no_done", 32'(nd - d0), 32'd0);
    check("stop_no_more", 32'(ne - b), 32'd1);

    // Write and start while busy.
    b = ne; d0 = nd;
    pulse_start();
    wait_ev("busy_first", b + 1);
    wr(2'd0, mk(1'b1, 1'b1, 10'd9, 16'd1));
    check("busy_err", 32'(prog_err), 32'd1);
    pulse_start();
    check("busy_err_clear", 32'(prog_err), 32'd0);
    check("busy_idx", 32'(cur_idx), 32'd0);
    wait_ev("busy_second", b + 2);
    check("busy_no_restart", 32'(ev_step[b+1]), 32'd7);
    check("busy_idx3", 32'(cur_idx), 32'd3);
    wait_done("busy_done", d0 + 1);
    b = ne;
    pulse_start();
    wait_ev("entry_kept_ev", b + 1);
    check("entry_kept", 32'(ev_step[b]), 32'd5);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // start and stop together from IDLE.
    b = ne;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    repeat (5) tick();
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_ev", 32'(ne - b), 32'd0);

    // Reset mid-DWELL clears everything including the table.
    b = ne; d0 = nd;
    pulse_start();
    wait_ev("rstmid_first", b + 1);
    tick();
    sys_rst = 1'b1;
    tick();
    check_reset_outputs("rstmid");
    sys_rst = 1'b0;
    b = ne;
    pulse_start();
    repeat (8) tick();
    check("rstmid_start_ignored", 32'(busy), 32'd0);
    check("rstmid_no_ev", 32'(ne - b), 32'd0);
    check("rstmid_no_done", 32'(nd - d0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
